// File: rtl/cdi_bus_fabric.sv
// CPU-side bus fabric for the CD-i scc68070 bus: decodes regions, drives registered
// chip-selects, inserts wait states or waits for external acks, and reports bus errors.
module cdi_bus_fabric #(
    parameter int                         NUM_REGIONS    = 6,
    parameter int                         DATA_W         = 16,
    parameter logic [NUM_REGIONS*24-1:0]  REGION_BASE    = {24'h200000, 24'h400000, 24'h310000,
                                                            24'h300000, 24'h320000, 24'h180000},
    parameter logic [NUM_REGIONS*24-1:0]  REGION_MASK    = {24'hF00000, 24'hF00000, 24'hFF0000,
                                                            24'hFF0000, 24'hFFC000, 24'hF80000},
    parameter logic [NUM_REGIONS*4-1:0]   REGION_WAIT    = {4'd3, 4'd2, 4'd2, 4'd0, 4'd0, 4'd1},
    parameter logic [NUM_REGIONS-1:0]     REGION_EXT_ACK = 6'b000100,
    parameter int                         TIMEOUT        = 255
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [22:0]                   cpu_addr,
    input  logic                          cpu_as,
    input  logic                          cpu_uds,
    input  logic                          cpu_lds,
    input  logic                          cpu_write_strobe,
    input  logic [NUM_REGIONS*DATA_W-1:0] region_dout,
    input  logic [NUM_REGIONS-1:0]        region_ack,
    output logic [NUM_REGIONS-1:0]        region_cs,
    output logic [DATA_W-1:0]             cpu_data_in,
    output logic                          cpu_bus_ack,
    output logic                          cpu_bus_err,
    output logic [23:0]                   err_addr,
    output logic                          err_valid,
    output logic [2:0]                    dbg_state,
    output logic                          dbg_write
);

    // Handshake: a request is cpu_as && (cpu_uds || cpu_lds) seen in IDLE; it is answered by
    // exactly one cycle of cpu_bus_ack or cpu_bus_err (never both), or by nothing if aborted.
    // A new request is only accepted after the CPU releases as or both strobes.

    localparam int         IDX_W   = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACCESS  = 3'd1,
        ACK     = 3'd2,
        ERR     = 3'd3,
        RECOVER = 3'd4
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [IDX_W-1:0]   sel_q;
    logic [3:0]         wait_q;
    logic [7:0]         tmo_q;
    logic [23:0]        req_addr_q;
    logic               req_write_q;

    logic [23:0]        addr_byte;
    logic               request;
    logic               hit_any;
    logic [IDX_W-1:0]   hit_idx;
    logic [3:0]         hit_wait;
    logic [NUM_REGIONS-1:0] hit_onehot;

    logic               cur_ext;
    logic               cur_ack;
    logic [DATA_W-1:0]  cur_dout;

    assign addr_byte = {cpu_addr, 1'b0};
    assign request   = cpu_as && (cpu_uds || cpu_lds);
    assign dbg_state = state_q;
    assign dbg_write = req_write_q;

    // Scan from the top down so the lowest matching index is the one left standing.
    always_comb begin
        hit_any    = 1'b0;
        hit_idx    = '0;
        hit_wait   = '0;
        hit_onehot = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if ((addr_byte & REGION_MASK[24*i +: 24]) ==
                (REGION_BASE[24*i +: 24] & REGION_MASK[24*i +: 24])) begin
                hit_any       = 1'b1;
                hit_idx       = IDX_W'(i);
                hit_wait      = REGION_WAIT[4*i +: 4];
                hit_onehot    = '0;
                hit_onehot[i] = 1'b1;
            end
        end
    end

    // Attributes of the region locked at request time.
    always_comb begin
        cur_ext  = 1'b0;
        cur_ack  = 1'b0;
        cur_dout = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (sel_q == IDX_W'(i)) begin
                cur_ext  = REGION_EXT_ACK[i];
                cur_ack  = region_ack[i];
                cur_dout = region_dout[DATA_W*i +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (request) begin
                    state_d = hit_any ? ACCESS : ERR;
                end
            end
            ACCESS: begin
                if (!cpu_as) begin
                    state_d = RECOVER;
                end else if (cur_ext) begin
                    if (cur_ack) begin
                        state_d = ACK;
                    end else if (tmo_q == TO_LAST) begin
                        state_d = ERR;
                    end
                end else if (wait_q == 4'd0) begin
                    state_d = ACK;
                end
            end
            ACK:     state_d = RECOVER;
            ERR:     state_d = RECOVER;
            RECOVER: begin
                if (!cpu_as || (!cpu_uds && !cpu_lds)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            wait_q      <= '0;
            tmo_q       <= '0;
            req_addr_q  <= '0;
            req_write_q <= 1'b0;
            region_cs   <= '0;
            cpu_data_in <= '0;
            cpu_bus_ack <= 1'b0;
            cpu_bus_err <= 1'b0;
            err_addr    <= '0;
            err_valid   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cpu_bus_ack <= (state_d == ACK);
            cpu_bus_err <= (state_d == ERR);
            case (state_q)
                IDLE: begin
                    if (request) begin
                        sel_q       <= hit_idx;
                        wait_q      <= hit_wait;
                        tmo_q       <= '0;
                        req_addr_q  <= addr_byte;
                        req_write_q <= cpu_write_strobe;
                        if (hit_any) begin
                            region_cs <= hit_onehot;
                        end
                    end
                end
                ACCESS: begin
                    if (wait_q != 4'd0) begin
                        wait_q <= wait_q - 4'd1;
                    end
                    if (tmo_q != TO_LAST) begin
                        tmo_q <= tmo_q + 8'd1;
                    end
                    if (state_d == ACK) begin
                        cpu_data_in <= cur_dout;
                    end
                end
                ERR: begin
                    if (!err_valid) begin
                        err_addr  <= req_addr_q;
                        err_valid <= 1'b1;
                    end
                end
                RECOVER: begin
                    if (state_d == IDLE) begin
                        region_cs <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cdi_bus_fabric.sv
// Directed bench for cdi_bus_fabric: a driver issues CPU cycles and pushes expected
// responses; a monitor pops and compares on every ack/err the fabric presents.
module tb_cdi_bus_fabric;

    localparam int N  = 6;
    localparam int DW = 16;
    localparam int SW = 2 + DW;

    // r0 MCD212 0x400000/F00000 w2, r1 ROM 0x180000/F80000 w1, r2 NVRAM 0x320000/FFC000 w0,
    // r3 slave 0x400000/FF0000 w3 (shadowed by r0), r4 other 0x500000/F00000 w15, r5 CDIC ext.
    localparam logic [N*24-1:0] BASE = {24'h300000, 24'h500000, 24'h400000,
                                        24'h320000, 24'h180000, 24'h400000};
    localparam logic [N*24-1:0] MASK = {24'hFF0000, 24'hF00000, 24'hFF0000,
                                        24'hFFC000, 24'hF80000, 24'hF00000};
    localparam logic [N*4-1:0]  WAITS = {4'd0, 4'd15, 4'd3, 4'd0, 4'd1, 4'd2};
    localparam logic [N-1:0]    EXT   = 6'b100000;

    logic              clk;
    logic              resetn;
    logic [22:0]       cpu_addr;
    logic              cpu_as;
    logic              cpu_uds;
    logic              cpu_lds;
    logic              cpu_write_strobe;
    logic [N*DW-1:0]   region_dout;
    logic [N-1:0]      region_ack;
    logic [N-1:0]      region_cs;
    logic [DW-1:0]     cpu_data_in;
    logic              cpu_bus_ack;
    logic              cpu_bus_err;
    logic [23:0]       err_addr;
    logic              err_valid;
    logic [2:0]        dbg_state;
    logic              dbg_write;

    int checks   = 0;
    int errors   = 0;
    int ack_seen = 0;
    int err_seen = 0;

    logic [SW-1:0] exp_q[$];

    cdi_bus_fabric #(
        .NUM_REGIONS   (N),
        .DATA_W        (DW),
        .REGION_BASE   (BASE),
        .REGION_MASK   (MASK),
        .REGION_WAIT   (WAITS),
        .REGION_EXT_ACK(EXT),
        .TIMEOUT       (8)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .cpu_addr        (cpu_addr),
        .cpu_as          (cpu_as),
        .cpu_uds         (cpu_uds),
        .cpu_lds         (cpu_lds),
        .cpu_write_strobe(cpu_write_strobe),
        .region_dout     (region_dout),
        .region_ack      (region_ack),
        .region_cs       (region_cs),
        .cpu_data_in     (cpu_data_in),
        .cpu_bus_ack     (cpu_bus_ack),
        .cpu_bus_err     (cpu_bus_err),
        .err_addr        (err_addr),
        .err_valid       (err_valid),
        .dbg_state       (dbg_state),
        .dbg_write       (dbg_write)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    // Driver tasks
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Presents a request right after a rising edge; returns at the negedge before the
    // edge that samples it (cycle 0).
    task automatic start_req(input logic [23:0] byte_addr, input logic u, input logic l,
                             input logic w);
        @(posedge clk);
        #1;
        cpu_addr         = byte_addr[23:1];
        cpu_as           = 1'b1;
        cpu_uds          = u;
        cpu_lds          = l;
        cpu_write_strobe = w;
        @(negedge clk);
    endtask

    task automatic end_req(input string name);
        cpu_as           = 1'b0;
        cpu_uds          = 1'b0;
        cpu_lds          = 1'b0;
        cpu_write_strobe = 1'b0;
        step();
        step();
        chk(name, 32'(region_cs), 32'h0);
    endtask

    task automatic push_ack(input logic [DW-1:0] d);
        exp_q.push_back({2'b10, d});
    endtask

    task automatic push_err();
        exp_q.push_back({2'b01, {DW{1'b0}}});
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [SW-1:0] e;
        if (resetn) begin
            if (cpu_bus_ack && cpu_bus_err) begin
                checks++;
                errors++;
                $display("FAIL ack_err_overlap: got ack=1 err=1 required exclusive");
            end else if (cpu_bus_ack || cpu_bus_err) begin
                if (cpu_bus_ack) ack_seen++;
                if (cpu_bus_err) err_seen++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_resp: got ack=%0b err=%0b required none",
                             cpu_bus_ack, cpu_bus_err);
                end else begin
                    e = exp_q.pop_front();
                    if (e[SW-1:SW-2] !== {cpu_bus_ack, cpu_bus_err} ||
                        (cpu_bus_ack && e[DW-1:0] !== cpu_data_in)) begin
                        errors++;
                        $display("FAIL resp: got ack=%0b err=%0b data=0x%0h required ack=%0b err=%0b data=0x%0h",
                                 cpu_bus_ack, cpu_bus_err, cpu_data_in, e[SW-1], e[SW-2], e[DW-1:0]);
                    end
                end
            end
        end
    end

    initial begin
        int n_ack;
        resetn           = 1'b0;
        cpu_addr         = '0;
        cpu_as           = 1'b0;
        cpu_uds          = 1'b0;
        cpu_lds          = 1'b0;
        cpu_write_strobe = 1'b0;
        region_ack       = '0;
        region_dout      = {16'h5555, 16'h4444, 16'h3333, 16'hA5A5, 16'hBEEF, 16'h1111};
        #23;
        chk("rst_cs", 32'(region_cs), 32'h0);
        chk("rst_ack_err", {30'd0, cpu_bus_ack, cpu_bus_err}, 32'h0);
        chk("rst_err_valid", 32'(err_valid), 32'h0);
        chk("rst_state", 32'(dbg_state), 32'h0);
        @(negedge clk);
        resetn = 1'b1;

        // ROM word read, one wait state
        start_req(24'h180010, 1'b1, 1'b1, 1'b0);
        push_ack(16'hBEEF);
        chk("rom_cs_c0", 32'(region_cs), 32'h0);
        step();
        chk("rom_cs_c1", 32'(region_cs), 32'b000010);
        step();
        chk("rom_ack_c2", 32'(cpu_bus_ack), 32'h0);
        step();
        chk("rom_ack_c3", 32'(cpu_bus_ack), 32'h1);
        chk("rom_data", 32'(cpu_data_in), 32'hBEEF);
        end_req("rom_cs_clear");

        // NVRAM byte write, zero wait, strobes held
        start_req(24'h320004, 1'b1, 1'b0, 1'b1);
        push_ack(16'hA5A5);
        step();
        chk("nv_cs_c1", 32'(region_cs), 32'b000100);
        chk("nv_write_flag", 32'(dbg_write), 32'h1);
        step();
        chk("nv_ack_c2", 32'(cpu_bus_ack), 32'h1);
        n_ack = 0;
        repeat (10) begin
            step();
            if (cpu_bus_ack) n_ack++;
        end
        chk("nv_held_no_reack", 32'(n_ack), 32'h0);
        chk("nv_cs_held", 32'(region_cs), 32'b000100);
        end_req("nv_cs_clear");
        start_req(24'h320004, 1'b1, 1'b0, 1'b1);
        push_ack(16'hA5A5);
        step();
        step();
        chk("nv_second_ack", 32'(cpu_bus_ack), 32'h1);
        end_req("nv2_cs_clear");

        // CDIC external ack, 5 cycles after cs
        start_req(24'h300000, 1'b1, 1'b1, 1'b0);
        push_ack(16'h5555);
        step();
        chk("ext_cs_c1", 32'(region_cs), 32'b100000);
        repeat (5) step();
        chk("ext_ack_c6", 32'(cpu_bus_ack), 32'h0);
        region_ack = 6'b100000;
        step();
        region_ack = '0;
        chk("ext_ack_c7", 32'(cpu_bus_ack), 32'h1);
        end_req("ext_cs_clear");

        // CDIC external ack never arrives: timeout after 8 cycles
        start_req(24'h300000, 1'b1, 1'b1, 1'b0);
        push_err();
        repeat (8) step();
        chk("tmo_err_c8", 32'(cpu_bus_err), 32'h0);
        step();
        chk("tmo_err_c9", 32'(cpu_bus_err), 32'h1);
        end_req("tmo_cs_clear");
        chk("tmo_err_addr", 32'(err_addr), 32'h300000);
        chk("tmo_err_valid", 32'(err_valid), 32'h1);

        // Asynchronous reset in the middle of a ROM access
        start_req(24'h180010, 1'b1, 1'b1, 1'b0);
        step();
        chk("rst_mid_cs_before", 32'(region_cs), 32'b000010);
        #2;
        resetn = 1'b0;
        #1;
        chk("rst_mid_cs", 32'(region_cs), 32'h0);
        chk("rst_mid_data", 32'(cpu_data_in), 32'h0);
        chk("rst_mid_err_addr", 32'(err_addr), 32'h0);
        chk("rst_mid_err_valid", 32'(err_valid), 32'h0);
        chk("rst_mid_state", 32'(dbg_state), 32'h0);
        cpu_as  = 1'b0;
        cpu_uds = 1'b0;
        cpu_lds = 1'b0;
        step();
        step();
        resetn = 1'b1;
        start_req(24'h180010, 1'b1, 1'b1, 1'b0);
        push_ack(16'hBEEF);
        step();
        chk("post_rst_cs", 32'(region_cs), 32'b000010);
        step();
        step();
        chk("post_rst_ack", 32'(cpu_bus_ack), 32'h1);
        end_req("post_rst_cs_clear");

        // Unmapped accesses: first error address is sticky
        start_req(24'h700000, 1'b1, 1'b1, 1'b0);
        push_err();
        step();
        chk("unm_err_c1", 32'(cpu_bus_err), 32'h1);
        chk("unm_no_cs", 32'(region_cs), 32'h0);
        end_req("unm_cs_clear");
        chk("unm_err_addr", 32'(err_addr), 32'h700000);
        chk("unm_err_valid", 32'(err_valid), 32'h1);
        start_req(24'hF00000, 1'b0, 1'b1, 1'b0);
        push_err();
        step();
        chk("unm2_err_c1", 32'(cpu_bus_err), 32'h1);
        end_req("unm2_cs_clear");
        chk("unm2_err_addr_kept", 32'(err_addr), 32'h700000);

        // Overlap: regions 0 and 3 both cover 0x400000
        start_req(24'h400000, 1'b1, 1'b1, 1'b0);
        push_ack(16'h1111);
        step();
        chk("ovl_cs", 32'(region_cs), 32'b000001);
        step();
        step();
        chk("ovl_ack_c3", 32'(cpu_bus_ack), 32'h0);
        step();
        chk("ovl_ack_c4", 32'(cpu_bus_ack), 32'h1);
        chk("ovl_data", 32'(cpu_data_in), 32'h1111);
        end_req("ovl_cs_clear");

        // Abort a wait-15 access at cycle 4
        start_req(24'h500000, 1'b1, 1'b1, 1'b0);
        step();
        chk("abt_cs_c1", 32'(region_cs), 32'b010000);
        repeat (3) step();
        cpu_as  = 1'b0;
        cpu_uds = 1'b0;
        cpu_lds = 1'b0;
        step();
        chk("abt_cs_c5", 32'(region_cs), 32'b010000);
        step();
        chk("abt_cs_c6", 32'(region_cs), 32'h0);
        n_ack = 0;
        repeat (20) begin
            step();
            if (cpu_bus_ack || cpu_bus_err) n_ack++;
        end
        chk("abt_no_resp", 32'(n_ack), 32'h0);

        // Final report
        chk("sb_empty", 32'(exp_q.size()), 32'h0);
        chk("ack_total", 32'(ack_seen), 32'd6);
        chk("err_total", 32'(err_seen), 32'd3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdi_bus_fabric.md
Name: cdi_bus_fabric

Overview:
- Parametrised CPU-side bus fabric for the CD-i platform. It sits between the scc68070 bus (addr/as/uds/lds/write_strobe) and N peripheral regions: ROM, NVRAM, CDIC, slave, MCD212 and others.
- It decodes regions from base/mask tables and generates registered per-region chip-selects. It inserts programmable wait states, or waits for an external per-region ack, and muxes read data.
- It produces single-cycle bus_ack, and raises bus_err on unmapped accesses or ack timeouts. It latches the address of the first error for debug readout.

Parameters:
- NUM_REGIONS, 6, number of decoded regions (1..16).
- DATA_W, 16, CPU data width.
- REGION_BASE, packed NUM_REGIONS*24 bits, byte base address per region; region i in bits [24*i+:24].
- REGION_MASK, packed NUM_REGIONS*24 bits, compare mask: region i hits when (addr_byte & mask_i) == (base_i & mask_i).
- REGION_WAIT, packed NUM_REGIONS*4 bits, wait states per region (0..15), used in internal-ack mode.
- REGION_EXT_ACK, NUM_REGIONS bits, 1 = region supplies its own ack on region_ack[i].
- TIMEOUT, 255, maximum cycles to wait for an external ack before bus_err (1..255).

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- cpu_addr  in  23  word address [23:1]; addr_byte = {cpu_addr, 1'b0}
- cpu_as  in  1  address strobe, active high
- cpu_uds  in  1  upper byte strobe, active high
- cpu_lds  in  1  lower byte strobe, active high
- cpu_write_strobe  in  1  1 = write cycle
- region_dout  in  NUM_REGIONS*DATA_W  read data from each region
- region_ack  in  NUM_REGIONS  external acks; only bits with REGION_EXT_ACK=1 are used
- region_cs  out  NUM_REGIONS  one-hot registered chip-select
- cpu_data_in  out  DATA_W  registered read data to CPU
- cpu_bus_ack  out  1  one-cycle transfer acknowledge
- cpu_bus_err  out  1  one-cycle bus error
- err_addr  out  24  byte address of the first error since reset
- err_valid  out  1  sticky: err_addr is valid

Behaviour:
- Reset (resetn low, asynchronous): state IDLE; region_cs=0, cpu_data_in=0, cpu_bus_ack=0, cpu_bus_err=0, err_addr=0, err_valid=0; counters cleared. A reset mid-access abandons the access with no ack.
- Request: cpu_as && (cpu_uds || cpu_lds), sampled at the clk edge in IDLE.
- Decode: combinational hit vector. With overlapping regions, the lowest index wins. No hit = unmapped.
- States and transitions:
  - IDLE:
    - Request hits region i → ACCESS; region_cs[i]=1 from the next cycle; wait counter = REGION_WAIT[i]; timeout counter = 0.
    - Request is unmapped → ERR.
  - ACCESS, internal mode: counter decrements each cycle. On the cycle the counter reads 0 → ACK. Result: cpu_bus_ack is high exactly W+1 cycles after region_cs rises (W=0 → ack on the cycle after cs).
  - ACCESS, external mode: on the edge where region_ack[i]=1 → ACK. Otherwise the timeout counter increments; when it reaches TIMEOUT → ERR.
  - ACCESS abort: cpu_as low at any edge in ACCESS → RECOVER; no ack, no error.
  - ACK: cpu_bus_ack=1 for one cycle. cpu_data_in = region_dout[i], captured on the edge entering ACK (also captured for writes; CPU ignores it) → RECOVER.
  - ERR: cpu_bus_err=1 for one cycle. If err_valid=0, latch addr_byte and set err_valid. Later errors do not overwrite → RECOVER.
  - RECOVER: region_cs held until cpu_as is low, or both strobes are low; then region_cs=0 → IDLE. This guarantees one dead cycle; a held strobe never double-acks.
- cpu_bus_ack and cpu_bus_err are never high in the same cycle.
- Exactly one region_cs bit is high at a time.
- The address is not re-decoded during an access: the region is locked at request.
- Timeout counter width is 8 bits; no wrap, because the compare triggers at TIMEOUT.

Test Plan:
- ROM region (base 0x180000, mask 0xF80000, wait 1): word read at 0x180010, region_dout=0xBEEF → region_cs high at cycle 1, cpu_bus_ack in cycle 3, cpu_data_in=0xBEEF, cs drops after as falls.
- NVRAM region, wait 0, held strobes: byte write uds=1 at 0x320004 → single ack on the cycle after cs. Holding as/uds for 10 more cycles gives no second ack; the next request after as drops gets a new ack.
- External-ack region (CDIC at 0x300000): region_ack asserted 5 cycles after cs → ack follows. Repeat with ack never asserted and TIMEOUT=8 → cpu_bus_err after 8 ACCESS cycles; err_addr=0x300000, err_valid=1.
- Unmapped address 0x700000 → cpu_bus_err on the cycle after request; no region_cs. A second unmapped access at 0xF00000 leaves err_addr=0x700000.
- Overlap priority: regions 0 and 3 both cover 0x400000 → only region_cs[0] is asserted. Abort during a wait-15 access by dropping as at cycle 4 → no ack, no err, cs clears.
- Async reset mid-access: resetn low during ACCESS, between clock edges → all outputs 0 immediately. After release, a new read completes normally.
